merlin_operand_fetch: RTL and testbench
=======================================

// Module: merlin_operand_fetch
// PURPOSE
//  Operand fetch stage driving the read ports of the integer register file.
//  Accepts decoded register-usage from decode and issues reads; the file's registered data returns next cycle.
//  Tracks outstanding writes in a 31-entry scoreboard, stalls RAW hazards and bypasses same-cycle writes.
//  Presents rs1/rs2 operands to execute over a valid/ready handshake.
// PARAMETERS
//  XLEN  32  operand/register data width
// PORTS
//  clk_i            in   1     clock
//  reset_i          in   1     synchronous, active-high reset
//  clk_en_i         in   1     clock enable; all state holds and no handshake completes when low
//  ins_valid_i      in   1     decode has an instruction
//  ins_ready_o      out  1     stage accepts instruction (combinational)
//  ins_rs1_en_i     in   1     instruction reads rs1
//  ins_rs1_addr_i   in   5     rs1 index
//  ins_rs2_en_i     in   1     instruction reads rs2
//  ins_rs2_addr_i   in   5     rs2 index
//  ins_rd_en_i      in   1     instruction will write rd
//  ins_rd_addr_i    in   5     rd index
//  rreg_a_rd_o      out  1     register file read strobe, port a (rs1)
//  rreg_a_addr_o    out  5     read address, port a
//  rreg_a_data_i    in   XLEN  registered read data, port a
//  rreg_b_rd_o      out  1     read strobe, port b (rs2)
//  rreg_b_addr_o    out  5     read address, port b
//  rreg_b_data_i    in   XLEN  registered read data, port b
//  wreg_a_wr_i      in   1     snoop of register file write port a
//  wreg_a_addr_i    in   5     write address a
//  wreg_a_data_i    in   XLEN  write data a
//  wreg_b_wr_i      in   1     snoop of register file write port b
//  wreg_b_addr_i    in   5     write address b
//  wreg_b_data_i    in   XLEN  write data b
//  op_valid_o       out  1     operands valid to execute
//  op_ready_i       in   1     execute accepts operands
//  op_rs1_data_o    out  XLEN  rs1 operand (0 if rs1 disabled or x0)
//  op_rs2_data_o    out  XLEN  rs2 operand (0 if rs2 disabled or x0)
//  op_rd_en_o       out  1     rd write flag carried with operands
//  op_rd_addr_o     out  5     rd index carried with operands
// BEHAVIOUR
//  Reset: op_valid_o=0, op_rd_en_o=0, op_rd_addr_o=0, scoreboard=0, bypass flags=0; rreg_*_rd_o=0 while reset_i high.
//  wr_x(r): wreg_a/b write to r!=0 this cycle. haz(rs): en & rs!=0 & pend[rs] & !wr_x(rs).
//  ins_ready_o = clk_en_i & !reset_i & !haz(rs1) & !haz(rs2) & (!op_valid_o | op_ready_i).
//  Accept = ins_valid_i & ins_ready_o: rreg_a_rd_o=rs1_en, rreg_b_rd_o=rs2_en, addr=rs fields, same cycle.
//  Latency 1: accept in cycle N -> op_valid_o=1 in N+1; full throughput with op_ready_i held high.
//  op_valid_o holds with stable data and rd fields until op_valid_o & op_ready_i & clk_en_i.
//  Bypass: file returns pre-write data on same-cycle read+write; on accept, if wr_x(rs) latch write data
//   plus flag, operand mux selects latched data over rreg_*_data_i. Both ports hit: port b wins.
//  Operand = 0 when rs disabled or index 0, regardless of file or bypass.
//  Scoreboard pend[1:31]: set on accept with rd_en & rd!=0; cleared by wreg_a/b write to that index.
//   Same-cycle set+clear of one index: set wins. Writes to x0 ignored.
//  rs==rd of same instruction: reads old value, no self-stall.
//  No writes to a pending source occur while op_valid_o holds (accept blocked by scoreboard), so no
//   bypass update is needed in hold.
//  reset_i mid-operation: in-flight operand dropped, scoreboard cleared next edge.
// TESTING
//  Reset, then rs1=3,rs2=5 (x3=0x11,x5=0x22), rd=7 -> op_valid N+1, ops 0x11/0x22, pend[7]=1.
//  Next ins reads x7 while pend[7] -> ins_ready_o=0; wreg_a writes x7=0xAB -> accept same cycle, rs1=0xAB.
//  Accept with wreg_a and wreg_b both writing rs2=9 (0x1,0x2) -> op_rs2_data_o=0x2, pend[9]=0.
//  op_ready_i low 4 cycles -> op_valid_o, data, rd fields stable; ins_ready_o=0 until handshake.
//  rs1=0, rd=0 -> op_rs1_data_o=0, rreg_a_rd_o=1 on accept, scoreboard unchanged.
//  clk_en_i low with ins_valid_i=1 -> no accept, no strobes; reset_i mid-hold -> op_valid_o=0, pend=0.

Source files
------------

// File: rtl/merlin_operand_fetch.sv
// rtl/merlin_operand_fetch.sv - operand fetch stage: register file reads, RAW scoreboard, write bypass
module merlin_operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clk_en_i,
    input  logic            ins_valid_i,
    output logic            ins_ready_o,
    input  logic            ins_rs1_en_i,
    input  logic [4:0]      ins_rs1_addr_i,
    input  logic            ins_rs2_en_i,
    input  logic [4:0]      ins_rs2_addr_i,
    input  logic            ins_rd_en_i,
    input  logic [4:0]      ins_rd_addr_i,
    output logic            rreg_a_rd_o,
    output logic [4:0]      rreg_a_addr_o,
    input  logic [XLEN-1:0] rreg_a_data_i,
    output logic            rreg_b_rd_o,
    output logic [4:0]      rreg_b_addr_o,
    input  logic [XLEN-1:0] rreg_b_data_i,
    input  logic            wreg_a_wr_i,
    input  logic [4:0]      wreg_a_addr_i,
    input  logic [XLEN-1:0] wreg_a_data_i,
    input  logic            wreg_b_wr_i,
    input  logic [4:0]      wreg_b_addr_i,
    input  logic [XLEN-1:0] wreg_b_data_i,
    output logic            op_valid_o,
    input  logic            op_ready_i,
    output logic [XLEN-1:0] op_rs1_data_o,
    output logic [XLEN-1:0] op_rs2_data_o,
    output logic            op_rd_en_o,
    output logic [4:0]      op_rd_addr_o
);

    logic [31:0]     pend_q;
    logic [31:0]     pend_d;
    logic            op_valid_q;
    logic            op_rd_en_q;
    logic [4:0]      op_rd_addr_q;
    logic            rs1_use_q;
    logic            rs2_use_q;
    logic            byp1_q;
    logic            byp2_q;
    logic [XLEN-1:0] byp1_data_q;
    logic [XLEN-1:0] byp2_data_q;

    logic hit_a1, hit_b1, hit_a2, hit_b2;
    logic haz1, haz2;
    logic accept;

    function automatic logic wr_hit(input logic we, input logic [4:0] wa, input logic [4:0] ra);
        return we && (wa != 5'd0) && (wa == ra);
    endfunction

    assign hit_a1 = wr_hit(wreg_a_wr_i, wreg_a_addr_i, ins_rs1_addr_i);
    assign hit_b1 = wr_hit(wreg_b_wr_i, wreg_b_addr_i, ins_rs1_addr_i);
    assign hit_a2 = wr_hit(wreg_a_wr_i, wreg_a_addr_i, ins_rs2_addr_i);
    assign hit_b2 = wr_hit(wreg_b_wr_i, wreg_b_addr_i, ins_rs2_addr_i);

    // A pending source that is being written this cycle is resolved by the bypass, not stalled.
    assign haz1 = ins_rs1_en_i && (ins_rs1_addr_i != 5'd0) && pend_q[ins_rs1_addr_i] && !(hit_a1 || hit_b1);
    assign haz2 = ins_rs2_en_i && (ins_rs2_addr_i != 5'd0) && pend_q[ins_rs2_addr_i] && !(hit_a2 || hit_b2);

    assign ins_ready_o = clk_en_i && !reset_i && !haz1 && !haz2 && (!op_valid_q || op_ready_i);
    assign accept      = ins_valid_i && ins_ready_o;

    assign rreg_a_rd_o   = accept && ins_rs1_en_i;
    assign rreg_a_addr_o = ins_rs1_addr_i;
    assign rreg_b_rd_o   = accept && ins_rs2_en_i;
    assign rreg_b_addr_o = ins_rs2_addr_i;

    // Clears first, then the accepted rd sets, so a same-cycle set of one index wins.
    always_comb begin
        pend_d = pend_q;
        if (wreg_a_wr_i) pend_d[wreg_a_addr_i] = 1'b0;
        if (wreg_b_wr_i) pend_d[wreg_b_addr_i] = 1'b0;
        if (accept && ins_rd_en_i) pend_d[ins_rd_addr_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q       <= '0;
            op_valid_q   <= 1'b0;
            op_rd_en_q   <= 1'b0;
            op_rd_addr_q <= 5'd0;
            rs1_use_q    <= 1'b0;
            rs2_use_q    <= 1'b0;
            byp1_q       <= 1'b0;
            byp2_q       <= 1'b0;
            byp1_data_q  <= '0;
            byp2_data_q  <= '0;
        end else if (clk_en_i) begin
            pend_q <= pend_d;
            if (accept) begin
                op_valid_q   <= 1'b1;
                op_rd_en_q   <= ins_rd_en_i;
                op_rd_addr_q <= ins_rd_addr_i;
                rs1_use_q    <= ins_rs1_en_i && (ins_rs1_addr_i != 5'd0);
                rs2_use_q    <= ins_rs2_en_i && (ins_rs2_addr_i != 5'd0);
                byp1_q       <= hit_a1 || hit_b1;
                byp2_q       <= hit_a2 || hit_b2;
                byp1_data_q  <= hit_b1 ? wreg_b_data_i : wreg_a_data_i;
                byp2_data_q  <= hit_b2 ? wreg_b_data_i : wreg_a_data_i;
            end else if (op_ready_i) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    // The file returns pre-write data on a same-cycle read+write, so latched bypass data takes priority.
    assign op_rs1_data_o = !rs1_use_q ? '0 : (byp1_q ? byp1_data_q : rreg_a_data_i);
    assign op_rs2_data_o = !rs2_use_q ? '0 : (byp2_q ? byp2_data_q : rreg_b_data_i);
    assign op_valid_o    = op_valid_q;
    assign op_rd_en_o    = op_rd_en_q;
    assign op_rd_addr_o  = op_rd_addr_q;

endmodule

// File: tb/tb_merlin_operand_fetch.sv
// tb/tb_merlin_operand_fetch.sv - scoreboard bench for merlin_operand_fetch
module tb_merlin_operand_fetch;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            reset_i, clk_en_i;
    logic            ins_valid_i, ins_ready_o;
    logic            ins_rs1_en_i, ins_rs2_en_i, ins_rd_en_i;
    logic [4:0]      ins_rs1_addr_i, ins_rs2_addr_i, ins_rd_addr_i;
    logic            rreg_a_rd_o, rreg_b_rd_o;
    logic [4:0]      rreg_a_addr_o, rreg_b_addr_o;
    logic [XLEN-1:0] rreg_a_data_i, rreg_b_data_i;
    logic            wreg_a_wr_i, wreg_b_wr_i;
    logic [4:0]      wreg_a_addr_i, wreg_b_addr_i;
    logic [XLEN-1:0] wreg_a_data_i, wreg_b_data_i;
    logic            op_valid_o, op_ready_i;
    logic [XLEN-1:0] op_rs1_data_o, op_rs2_data_o;
    logic            op_rd_en_o;
    logic [4:0]      op_rd_addr_o;

    always #5 clk_i = ~clk_i;

    merlin_operand_fetch #(.XLEN(XLEN)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o),
        .ins_rs1_en_i(ins_rs1_en_i), .ins_rs1_addr_i(ins_rs1_addr_i),
        .ins_rs2_en_i(ins_rs2_en_i), .ins_rs2_addr_i(ins_rs2_addr_i),
        .ins_rd_en_i(ins_rd_en_i), .ins_rd_addr_i(ins_rd_addr_i),
        .rreg_a_rd_o(rreg_a_rd_o), .rreg_a_addr_o(rreg_a_addr_o), .rreg_a_data_i(rreg_a_data_i),
        .rreg_b_rd_o(rreg_b_rd_o), .rreg_b_addr_o(rreg_b_addr_o), .rreg_b_data_i(rreg_b_data_i),
        .wreg_a_wr_i(wreg_a_wr_i), .wreg_a_addr_i(wreg_a_addr_i), .wreg_a_data_i(wreg_a_data_i),
        .wreg_b_wr_i(wreg_b_wr_i), .wreg_b_addr_i(wreg_b_addr_i), .wreg_b_data_i(wreg_b_data_i),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .op_rs1_data_o(op_rs1_data_o), .op_rs2_data_o(op_rs2_data_o),
        .op_rd_en_o(op_rd_en_o), .op_rd_addr_o(op_rd_addr_o)
    );

    // Register file environment: registered reads return pre-write data, port b write wins.
    logic [XLEN-1:0] rf [32];
    always @(posedge clk_i) begin
        if (rreg_a_rd_o) rreg_a_data_i <= rf[rreg_a_addr_o];
        if (rreg_b_rd_o) rreg_b_data_i <= rf[rreg_b_addr_o];
        if (wreg_a_wr_i && wreg_a_addr_i != 5'd0) rf[wreg_a_addr_i] <= wreg_a_data_i;
        if (wreg_b_wr_i && wreg_b_addr_i != 5'd0) rf[wreg_b_addr_i] <= wreg_b_data_i;
    end

    typedef struct {
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic            rde;
        logic [4:0]      rd;
    } exp_t;

    exp_t            exp_q[$];
    logic [XLEN-1:0] regs [32];
    logic [31:0]     pend_m;
    logic            mv_valid;
    int              tests = 0;
    int              fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic written(input logic [4:0] r);
        return (r != 5'd0) && ((wreg_a_wr_i && wreg_a_addr_i == r) || (wreg_b_wr_i && wreg_b_addr_i == r));
    endfunction

    // Architectural value of a source as seen by this instruction, including this cycle's writes.
    function automatic logic [XLEN-1:0] src_val(input logic en, input logic [4:0] r);
        if (!en || r == 5'd0) return '0;
        if (wreg_b_wr_i && wreg_b_addr_i == r) return wreg_b_data_i;
        if (wreg_a_wr_i && wreg_a_addr_i == r) return wreg_a_data_i;
        return regs[r];
    endfunction

    task automatic set_ins(input logic v, input logic e1, input logic [4:0] a1, input logic e2,
                           input logic [4:0] a2, input logic rde, input logic [4:0] rd);
        ins_valid_i = v; ins_rs1_en_i = e1; ins_rs1_addr_i = a1;
        ins_rs2_en_i = e2; ins_rs2_addr_i = a2; ins_rd_en_i = rde; ins_rd_addr_i = rd;
    endtask

    task automatic set_wr(input logic wa, input logic [4:0] aa, input logic [31:0] da,
                          input logic wb, input logic [4:0] ab, input logic [31:0] db);
        wreg_a_wr_i = wa; wreg_a_addr_i = aa; wreg_a_data_i = da;
        wreg_b_wr_i = wb; wreg_b_addr_i = ab; wreg_b_data_i = db;
    endtask

    task automatic step();
        logic h1, h2, rdy, acc;
        exp_t e;
        @(negedge clk_i);
        h1  = ins_rs1_en_i && ins_rs1_addr_i != 5'd0 && pend_m[ins_rs1_addr_i] && !written(ins_rs1_addr_i);
        h2  = ins_rs2_en_i && ins_rs2_addr_i != 5'd0 && pend_m[ins_rs2_addr_i] && !written(ins_rs2_addr_i);
        rdy = clk_en_i && !reset_i && !h1 && !h2 && (!mv_valid || op_ready_i);
        acc = ins_valid_i && rdy;
        check("op_valid", {31'd0, op_valid_o}, {31'd0, mv_valid});
        check("ins_ready", {31'd0, ins_ready_o}, {31'd0, rdy});
        check("rd_strobe_a", {31'd0, rreg_a_rd_o}, {31'd0, acc && ins_rs1_en_i});
        check("rd_strobe_b", {31'd0, rreg_b_rd_o}, {31'd0, acc && ins_rs2_en_i});
        if (acc && ins_rs1_en_i) check("rd_addr_a", {27'd0, rreg_a_addr_o}, {27'd0, ins_rs1_addr_i});
        if (acc && ins_rs2_en_i) check("rd_addr_b", {27'd0, rreg_b_addr_o}, {27'd0, ins_rs2_addr_i});
        if (acc) begin
            e.r1 = src_val(ins_rs1_en_i, ins_rs1_addr_i);
            e.r2 = src_val(ins_rs2_en_i, ins_rs2_addr_i);
            e.rde = ins_rd_en_i;
            e.rd = ins_rd_addr_i;
            exp_q.push_back(e);
        end
        if (reset_i) begin
            pend_m = '0;
            mv_valid = 1'b0;
            exp_q.delete();
        end else if (clk_en_i) begin
            if (mv_valid && op_ready_i) mv_valid = 1'b0;
            if (acc) mv_valid = 1'b1;
            if (wreg_a_wr_i) pend_m[wreg_a_addr_i] = 1'b0;
            if (wreg_b_wr_i) pend_m[wreg_b_addr_i] = 1'b0;
            if (acc && ins_rd_en_i && ins_rd_addr_i != 5'd0) pend_m[ins_rd_addr_i] = 1'b1;
        end
        if (wreg_a_wr_i && wreg_a_addr_i != 5'd0) regs[wreg_a_addr_i] = wreg_a_data_i;
        if (wreg_b_wr_i && wreg_b_addr_i != 5'd0) regs[wreg_b_addr_i] = wreg_b_data_i;
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every cycle operands are presented they must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!reset_i && op_valid_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL op_spurious: got op_valid_o=1, expected no operands at %0t", $time);
                end else begin
                    check("op_rs1", op_rs1_data_o, exp_q[0].r1);
                    check("op_rs2", op_rs2_data_o, exp_q[0].r2);
                    check("op_rd_en", {31'd0, op_rd_en_o}, {31'd0, exp_q[0].rde});
                    check("op_rd_addr", {27'd0, op_rd_addr_o}, {27'd0, exp_q[0].rd});
                    if (op_ready_i && clk_en_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int pq[$];
        logic [31:0] v;
        regs[0] = '0;
        pend_m = '0;
        mv_valid = 1'b0;
        reset_i = 1'b1; clk_en_i = 1'b1; op_ready_i = 1'b1;
        set_ins(0, 0, 0, 0, 0, 0, 0);
        set_wr(0, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        // Load the file through the write ports while reset is held.
        for (int i = 1; i < 32; i += 2) begin
            v = (i == 3) ? 32'h11 : (i == 5) ? 32'h22 : $urandom;
            set_wr(1, 5'(i), v, i < 31, 5'(i + 1), (i + 1 == 5) ? 32'h22 : $urandom);
            step();
        end
        set_wr(0, 0, 0, 0, 0, 0);
        step();
        reset_i = 1'b0;
        check("reset_op_valid", {31'd0, op_valid_o}, 32'd0);
        check("reset_rd_en", {31'd0, op_rd_en_o}, 32'd0);
        check("reset_rd_addr", {27'd0, op_rd_addr_o}, 32'd0);

        set_ins(1, 1, 3, 1, 5, 1, 7);
        step();
        check("first_rs1", op_rs1_data_o, 32'h11);
        check("first_rs2", op_rs2_data_o, 32'h22);
        check("first_rd", {27'd0, op_rd_addr_o}, 32'd7);

        set_ins(1, 1, 7, 0, 0, 0, 0);
        step();
        set_wr(1, 7, 32'hAB, 0, 0, 0);
        step();
        check("bypass_rs1", op_rs1_data_o, 32'hAB);
        set_wr(0, 0, 0, 0, 0, 0);

        set_ins(1, 0, 0, 1, 9, 0, 0);
        set_wr(1, 9, 32'h1, 1, 9, 32'h2);
        step();
        check("bypass_b_wins", op_rs2_data_o, 32'h2);
        set_wr(0, 0, 0, 0, 0, 0);

        set_ins(1, 1, 3, 1, 9, 1, 12);
        step();
        op_ready_i = 1'b0;
        set_ins(1, 1, 4, 0, 0, 0, 0);
        repeat (4) step();
        op_ready_i = 1'b1;
        step();

        set_ins(1, 1, 0, 0, 0, 0, 0);
        step();
        check("x0_operand", op_rs1_data_o, 32'd0);

        clk_en_i = 1'b0;
        set_ins(1, 1, 2, 1, 3, 1, 4);
        repeat (3) step();
        clk_en_i = 1'b1;
        set_ins(0, 0, 0, 0, 0, 0, 0);
        step();

        set_ins(1, 1, 2, 0, 0, 1, 6);
        step();
        op_ready_i = 1'b0;
        set_ins(0, 0, 0, 0, 0, 0, 0);
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        op_ready_i = 1'b1;
        check("reset_mid_hold", {31'd0, op_valid_o}, 32'd0);
        set_ins(1, 1, 6, 1, 12, 0, 0);
        step();

        for (int n = 0; n < 3000; n++) begin
            reset_i    = (n % 1000 == 999);
            clk_en_i   = ($urandom_range(0, 9) != 0);
            op_ready_i = ($urandom_range(0, 3) != 0);
            set_ins($urandom_range(0, 2) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
                    1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)));
            pq.delete();
            for (int r = 1; r < 32; r++) if (pend_m[r]) pq.push_back(r);
            set_wr(0, 0, 0, 0, 0, 0);
            if (clk_en_i) begin
                if (pq.size() != 0 && $urandom_range(0, 1) == 1)
                    set_wr(1, 5'(pq[$urandom_range(0, pq.size() - 1)]), $urandom, 0, 0, 0);
                else if ($urandom_range(0, 3) == 0)
                    set_wr(1, 5'($urandom_range(0, 7)), $urandom, 0, 0, 0);
                if ($urandom_range(0, 2) == 0) begin
                    wreg_b_wr_i   = 1'b1;
                    wreg_b_addr_i = (pq.size() != 0 && $urandom_range(0, 1) == 1) ?
                                    5'(pq[$urandom_range(0, pq.size() - 1)]) : 5'($urandom_range(0, 7));
                    wreg_b_data_i = $urandom;
                end
            end
            step();
        end

        reset_i = 1'b0; clk_en_i = 1'b1; op_ready_i = 1'b1;
        set_ins(0, 0, 0, 0, 0, 0, 0);
        set_wr(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
